data_bus_adapter: RTL and testbench
===================================

# data_bus_adapter

Core-side adapter that sits directly upstream of the data memory bus and turns one core load/store per instruction into bus transactions. It handles byte/half/word alignment, byte-enable generation, store-data replication, load extraction with sign/zero extension, and misalignment detection. It follows the bus's `wait_req`/`valid` handshake and stalls the core until each access completes. At most one read is outstanding at a time.

## Interface
Parameters:
- `BUS_TIMEOUT`, default 0: if nonzero, a read still awaiting `bus_valid` after this many cycles completes with `core_bus_error`; 0 disables the timeout.

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `core_address`  in  32  byte address
- `core_write_data`  in  32  store data, right-aligned
- `core_width`  in  2  access width: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- `core_unsigned`  in  1  load zero-extends when 1
- `core_read_req`  in  1  load request; held stable by core while `core_stall`=1
- `core_write_req`  in  1  store request; held stable by core while `core_stall`=1
- `core_stall`  out  1  access not yet complete
- `core_read_data`  out  32  extended load result; meaningful only when `core_read_valid`=1
- `core_read_valid`  out  1  one-cycle load-completion strobe
- `core_misaligned`  out  1  one-cycle strobe; access rejected
- `core_bus_error`  out  1  one-cycle strobe; read timed out
- `bus_address`  out  32  word-aligned address: `{core_address[31:2],2'b00}`
- `bus_write_data`  out  32  replicated store data
- `bus_byte_enable`  out  4  lane enables
- `bus_read_enable`  out  1  read request
- `bus_write_enable`  out  1  write request
- `bus_wait_req`  in  1  bus refuses a new request this cycle
- `bus_read_data`  in  32  bus load data
- `bus_valid`  in  1  load data valid

## Operation
- **Handshake:** a bus request is accepted on a rising edge where the request is asserted and `bus_wait_req`=0. Bus outputs are combinational from core inputs in `IDLE`.
- **Byte enables:** byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << addr[1:0]`; word → `4'b1111`.
- **Store data:** byte → `{4{wd[7:0]}}`; half → `{2{wd[15:0]}}`; word → `wd`.
- **Misalignment:** a half at an odd address, or a word with `addr[1:0]`≠0. No bus request is issued, `core_misaligned`=1 for that cycle, and `core_stall`=0.
- **Both requests asserted:** treated as a read; the write is ignored.

State machine:
- **`IDLE`**
  - Read request with `bus_wait_req`=0 → `WAIT`. Latch `addr[1:0]`, width and unsigned; `core_stall`=1.
  - Read request with `bus_wait_req`=1 → stay in `IDLE`; `core_stall`=1; keep the request asserted.
  - Write request with `bus_wait_req`=0 → completes this cycle; `core_stall`=0.
  - Write request with `bus_wait_req`=1 → `core_stall`=1; retry next cycle.
- **`WAIT`**
  - Bus outputs inactive (`bus_read_enable`=`bus_write_enable`=0).
  - On `bus_valid`=1: `core_read_valid`=1, `core_stall`=0, `core_read_data` = extracted lane. Byte lane is `rd[8*off +: 8]`, half lane is `rd[16*off[1] +: 16]`. Sign-extend unless the latched unsigned bit is set. → `IDLE`.
  - With `BUS_TIMEOUT`≠0: a counter starts at 0 on entry and increments each cycle without `bus_valid`. When it reaches `BUS_TIMEOUT`: `core_bus_error`=1, `core_stall`=0, `core_read_data`=0, → `IDLE`.
  - A late `bus_valid` arriving in `IDLE` is ignored.
- **`bus_valid` in `IDLE`** (no read outstanding) is ignored.

Reset:
- State `IDLE`, counter 0, and write buffer empty.
- Every output is 0, except those combinationally following core inputs. Those are still 0 while `reset`=1.
- Reset in mid-read abandons the read.

## Timing
- Read with bus latency L and no wait: request at cycle 0, `bus_valid` at cycle L. `core_read_valid` and `core_read_data` appear at cycle L, with `core_stall`=0 in that same cycle. The core stalls for L cycles (0..L-1).
- Write with no wait: zero stall cycles.
- Each `bus_wait_req` cycle adds one stall cycle before acceptance.
- Misaligned access: zero stall cycles; strobe in the request cycle.
- The next request may be presented in the cycle after completion.

## Configuration
- Macro `DATA_BUS_WRITE_BUFFER_EN`.
- **Defined:** one-entry write buffer. A write in `IDLE` completes in its request cycle (`core_stall`=0) regardless of `bus_wait_req`.
  - Address, byte enables and data are captured into the buffer when the bus would refuse, or when the buffer already holds an entry.
  - The buffer drives `bus_write_enable` until it is accepted.
  - A write arriving while the buffer is full stalls until the buffer drains.
  - A read stalls in `IDLE` while the buffer is non-empty. The buffer drains first, then the read issues.
- **Undefined:** no buffer; behaviour exactly as in Operation.

## Test plan
- Word read at `0x1000`, bus returns `0x8000_00F0` with L=5 → `core_stall` high cycles 0–4; at cycle 5 `core_read_valid`=1 and `core_read_data`=`0x8000_00F0`.
- Byte read at `0x1003`, signed, data `0x80xx_xxxx` → `0xFFFF_FF80`; same access unsigned → `0x0000_0080`.
- Half write `0xBEEF` at `0x1002` → `bus_byte_enable`=`4'b1100`, `bus_write_data`=`0xBEEF_BEEF`, zero stall.
- Word read at `0x1001` → no bus request, `core_misaligned`=1 for one cycle, no stall.
- `bus_wait_req` held 3 cycles on a read → acceptance on the 4th cycle; completion L cycles later.
- With `DATA_BUS_WRITE_BUFFER_EN`, a write under `bus_wait_req`=1 followed by a read → write completes with no stall; the read waits until the buffered write is accepted, then issues.

Source files
------------

// File: rtl/data_bus_adapter.sv
// Core-to-data-bus adapter: alignment, byte enables, store replication, load extension, misalignment and read timeout.
// Optional one-entry write buffer enabled by defining DATA_BUS_WRITE_BUFFER_EN.
module data_bus_adapter #(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [1:0]  core_width,
  input  logic        core_unsigned,
  input  logic        core_read_req,
  input  logic        core_write_req,
  output logic        core_stall,
  output logic [31:0] core_read_data,
  output logic        core_read_valid,
  output logic        core_misaligned,
  output logic        core_bus_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic        bus_wait_req,
  input  logic [31:0] bus_read_data,
  input  logic        bus_valid
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state, next_state;
  logic [31:0] timeout_count, timeout_count_next;
  logic        latch_en;
  logic [1:0]  lat_offset;
  logic [1:0]  lat_width;
  logic        lat_unsigned;

  logic        is_read, is_write, misaligned;
  logic [31:0] word_addr;
  logic [3:0]  lane_be;
  logic [31:0] rep_data;
  logic        wb_busy;

`ifdef DATA_BUS_WRITE_BUFFER_EN
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_be;
  logic        wb_capture, wb_drain;
  assign wb_busy = wb_valid;
`else
  assign wb_busy = 1'b0;
`endif

  // A simultaneous read and write is handled as a read; the write is dropped.
  assign is_read   = core_read_req;
  assign is_write  = core_write_req & ~core_read_req;
  assign word_addr = {core_address[31:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'b1111;
    rep_data   = core_write_data;
    case (core_width)
      2'd0: begin
        lane_be  = 4'b0001 << core_address[1:0];
        rep_data = {4{core_write_data[7:0]}};
      end
      2'd1: begin
        misaligned = core_address[0];
        lane_be    = 4'b0011 << core_address[1:0];
        rep_data   = {2{core_write_data[15:0]}};
      end
      default: misaligned = (core_address[1:0] != 2'b00);
    endcase
  end

  function automatic logic [31:0] extract_lane(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] width, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (width)
      2'd0:    extract_lane = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    extract_lane = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract_lane = rd;
    endcase
  endfunction

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    next_state         = state;
    timeout_count_next = timeout_count;
    latch_en           = 1'b0;
    core_stall         = 1'b0;
    core_read_data     = 32'b0;
    core_read_valid    = 1'b0;
    core_misaligned    = 1'b0;
    core_bus_error     = 1'b0;
    bus_address        = 32'b0;
    bus_write_data     = 32'b0;
    bus_byte_enable    = 4'b0;
    bus_read_enable    = 1'b0;
    bus_write_enable   = 1'b0;
`ifdef DATA_BUS_WRITE_BUFFER_EN
    wb_capture = 1'b0;
    wb_drain   = 1'b0;
`endif

    if (!reset) begin
      case (state)
        ST_IDLE: begin
`ifdef DATA_BUS_WRITE_BUFFER_EN
          // A buffered write owns the bus until it is accepted.
          if (wb_valid) begin
            bus_address      = wb_addr;
            bus_write_data   = wb_data;
            bus_byte_enable  = wb_be;
            bus_write_enable = 1'b1;
            wb_drain         = ~bus_wait_req;
          end
`endif
          if ((is_read || is_write) && misaligned) begin
            core_misaligned = 1'b1;
          end else if (is_read) begin
            core_stall = 1'b1;
            if (!wb_busy) begin
              bus_address     = word_addr;
              bus_byte_enable = lane_be;
              bus_read_enable = 1'b1;
              if (!bus_wait_req) begin
                next_state         = ST_WAIT;
                latch_en           = 1'b1;
                timeout_count_next = 32'b0;
              end
            end
          end else if (is_write) begin
`ifdef DATA_BUS_WRITE_BUFFER_EN
            if (!wb_valid) begin
              bus_address      = word_addr;
              bus_write_data   = rep_data;
              bus_byte_enable  = lane_be;
              bus_write_enable = 1'b1;
              wb_capture       = bus_wait_req;
            end else if (bus_wait_req) begin
              core_stall = 1'b1;
            end else begin
              wb_capture = 1'b1;
            end
`else
            bus_address      = word_addr;
            bus_write_data   = rep_data;
            bus_byte_enable  = lane_be;
            bus_write_enable = 1'b1;
            core_stall       = bus_wait_req;
`endif
          end
        end

        ST_WAIT: begin
          if (bus_valid) begin
            core_read_valid = 1'b1;
            core_read_data  = extract_lane(bus_read_data, lat_offset, lat_width, lat_unsigned);
            next_state      = ST_IDLE;
          end else if ((BUS_TIMEOUT != 0) && (timeout_count == BUS_TIMEOUT)) begin
            core_bus_error = 1'b1;
            next_state     = ST_IDLE;
          end else begin
            core_stall         = 1'b1;
            timeout_count_next = timeout_count + 32'd1;
          end
        end

        default: next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      timeout_count <= 32'b0;
    end else begin
      state         <= next_state;
      timeout_count <= timeout_count_next;
    end
  end

  // NOTE: payload registers are only read when a valid/state flag says so, so they carry no reset.
  always_ff @(posedge clock) begin
    if (latch_en) begin
      lat_offset   <= core_address[1:0];
      lat_width    <= core_width;
      lat_unsigned <= core_unsigned;
    end
  end

`ifdef DATA_BUS_WRITE_BUFFER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (wb_capture) begin
      wb_valid <= 1'b1;
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wb_capture) begin
      wb_addr <= word_addr;
      wb_be   <= lane_be;
      wb_data <= rep_data;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_adapter.sv
// Directed self-checking bench for data_bus_adapter (BUS_TIMEOUT set to 6 so the timeout path is exercised).
module tb_data_bus_adapter;

  localparam int unsigned TIMEOUT = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic [1:0]  core_width;
  logic        core_unsigned, core_read_req, core_write_req;
  logic        core_stall, core_read_valid, core_misaligned, core_bus_error;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable, bus_wait_req, bus_valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_bus_adapter #(.BUS_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_width(core_width), .core_unsigned(core_unsigned),
    .core_read_req(core_read_req), .core_write_req(core_write_req),
    .core_stall(core_stall), .core_read_data(core_read_data),
    .core_read_valid(core_read_valid), .core_misaligned(core_misaligned),
    .core_bus_error(core_bus_error),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_wait_req(bus_wait_req),
    .bus_read_data(bus_read_data), .bus_valid(bus_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    core_read_req  = 1'b0;
    core_write_req = 1'b0;
    bus_wait_req   = 1'b0;
    bus_valid      = 1'b0;
    bus_read_data  = 32'b0;
  endtask

  // Read: `waits` refused cycles, then acceptance (cycle 0), bus_valid at cycle `lat`.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] width,
                         input logic uns, input int waits, input int lat, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    int stalls = 0;
    core_address  = addr;
    core_width    = width;
    core_unsigned = uns;
    core_read_req = 1'b1;
    for (int i = 0; i < waits; i++) begin
      bus_wait_req = 1'b1;
      @(negedge clock);
      check({tag, " refused re"}, 32'(bus_read_enable), 32'd1);
      if (core_stall) stalls++;
      next_cycle();
    end
    bus_wait_req = 1'b0;
    @(negedge clock);
    check({tag, " re"}, 32'(bus_read_enable), 32'd1);
    check({tag, " addr"}, bus_address, {addr[31:2], 2'b00});
    check({tag, " be"}, 32'(bus_byte_enable), 32'(exp_be));
    if (core_stall) stalls++;
    next_cycle();
    for (int i = 1; i < lat; i++) begin
      @(negedge clock);
      check({tag, " wait re"}, 32'(bus_read_enable), 32'd0);
      check({tag, " wait rvalid"}, 32'(core_read_valid), 32'd0);
      if (core_stall) stalls++;
      next_cycle();
    end
    bus_valid     = 1'b1;
    bus_read_data = rdata;
    @(negedge clock);
    check({tag, " rvalid"}, 32'(core_read_valid), 32'd1);
    check({tag, " rdata"}, core_read_data, exp_data);
    check({tag, " done stall"}, 32'(core_stall), 32'd0);
    check({tag, " stall cycles"}, 32'(stalls), 32'(waits + lat));
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check({tag, " rvalid after"}, 32'(core_read_valid), 32'd0);
    next_cycle();
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [1:0] width,
                          input logic [31:0] wd, input int waits, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    core_address    = addr;
    core_width      = width;
    core_write_data = wd;
    core_write_req  = 1'b1;
    for (int i = 0; i < waits; i++) begin
      bus_wait_req = 1'b1;
      @(negedge clock);
      check({tag, " refused stall"}, 32'(core_stall), 32'd1);
      check({tag, " refused we"}, 32'(bus_write_enable), 32'd1);
      next_cycle();
    end
    bus_wait_req = 1'b0;
    @(negedge clock);
    check({tag, " stall"}, 32'(core_stall), 32'd0);
    check({tag, " we"}, 32'(bus_write_enable), 32'd1);
    check({tag, " addr"}, bus_address, {addr[31:2], 2'b00});
    check({tag, " be"}, 32'(bus_byte_enable), 32'(exp_be));
    check({tag, " wdata"}, bus_write_data, exp_data);
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_misaligned(input string tag, input logic [31:0] addr, input logic [1:0] width,
                               input logic rd);
    core_address   = addr;
    core_width     = width;
    core_read_req  = rd;
    core_write_req = ~rd;
    @(negedge clock);
    check({tag, " misaligned"}, 32'(core_misaligned), 32'd1);
    check({tag, " stall"}, 32'(core_stall), 32'd0);
    check({tag, " no req"}, {30'b0, bus_read_enable, bus_write_enable}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check({tag, " strobe drops"}, 32'(core_misaligned), 32'd0);
    next_cycle();
  endtask

  initial begin
    reset           = 1'b1;
    core_address    = 32'h0000_1004;
    core_write_data = 32'h0;
    core_width      = 2'd2;
    core_unsigned   = 1'b0;
    core_read_req   = 1'b1;
    core_write_req  = 1'b0;
    bus_wait_req    = 1'b0;
    bus_valid       = 1'b0;
    bus_read_data   = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("reset re", 32'(bus_read_enable), 32'd0);
    check("reset addr", bus_address, 32'd0);
    check("reset stall", 32'(core_stall), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    next_cycle();

    do_read("rd word L5", 32'h0000_1000, 2'd2, 1'b0, 0, 5, 32'h8000_00F0, 4'b1111, 32'h8000_00F0);
    do_read("rd byte s", 32'h0000_1003, 2'd0, 1'b0, 0, 2, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    do_read("rd byte u", 32'h0000_1003, 2'd0, 1'b1, 0, 2, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    do_read("rd half s", 32'h0000_1002, 2'd1, 1'b0, 0, 1, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
    do_read("rd half u", 32'h0000_1000, 2'd1, 1'b1, 0, 1, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);
    do_read("rd byte1", 32'h0000_1001, 2'd0, 1'b0, 0, 3, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
    do_read("rd wait3", 32'h0000_2000, 2'd2, 1'b0, 3, 4, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

    do_write("wr half", 32'h0000_1002, 2'd1, 32'h0000_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    do_write("wr word", 32'h0000_1004, 2'd2, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
`ifndef DATA_BUS_WRITE_BUFFER_EN
    do_write("wr byte wait2", 32'h0000_1001, 2'd0, 32'h1234_5678, 2, 4'b0010, 32'h7878_7878);
`endif

    do_misaligned("mis rd word", 32'h0000_1001, 2'd2, 1'b1);
    do_misaligned("mis wr half", 32'h0000_1003, 2'd1, 1'b0);
    do_misaligned("mis rd rsvd", 32'h0000_1002, 2'd3, 1'b1);

    // Both requests: only the read reaches the bus.
    core_address   = 32'h0000_1000;
    core_width     = 2'd2;
    core_read_req  = 1'b1;
    core_write_req = 1'b1;
    bus_wait_req   = 1'b1;
    @(negedge clock);
    check("both re", 32'(bus_read_enable), 32'd1);
    check("both we", 32'(bus_write_enable), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // bus_valid with no read outstanding is ignored.
    bus_valid     = 1'b1;
    bus_read_data = 32'h5555_5555;
    @(negedge clock);
    check("idle valid ignored", 32'(core_read_valid), 32'd0);
    next_cycle();
    idle_inputs();

    // Timeout: accepted at cycle 0, error strobe at cycle TIMEOUT+1.
    core_address  = 32'h0000_3000;
    core_width    = 2'd2;
    core_read_req = 1'b1;
    next_cycle();
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      @(negedge clock);
      check("to stall", 32'(core_stall), 32'd1);
      check("to no err", 32'(core_bus_error), 32'd0);
      next_cycle();
    end
    @(negedge clock);
    check("to err", 32'(core_bus_error), 32'd1);
    check("to stall end", 32'(core_stall), 32'd0);
    check("to rdata", core_read_data, 32'd0);
    next_cycle();
    core_read_req = 1'b0;
    bus_valid     = 1'b1;
    bus_read_data = 32'h1111_1111;
    @(negedge clock);
    check("late valid ignored", 32'(core_read_valid), 32'd0);
    check("err one cycle", 32'(core_bus_error), 32'd0);
    next_cycle();
    idle_inputs();

    // Reset while a read is outstanding abandons it.
    core_address  = 32'h0000_4000;
    core_read_req = 1'b1;
    next_cycle();
    reset         = 1'b1;
    core_read_req = 1'b0;
    next_cycle();
    reset     = 1'b0;
    bus_valid = 1'b1;
    @(negedge clock);
    check("rst abandon rvalid", 32'(core_read_valid), 32'd0);
    check("rst abandon stall", 32'(core_stall), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

`ifdef DATA_BUS_WRITE_BUFFER_EN
    // Refused write is buffered without stall; the following read waits for the drain.
    core_address    = 32'h0000_1008;
    core_width      = 2'd2;
    core_write_data = 32'h1122_3344;
    core_write_req  = 1'b1;
    bus_wait_req    = 1'b1;
    @(negedge clock);
    check("wb wr stall", 32'(core_stall), 32'd0);
    next_cycle();
    core_write_req = 1'b0;
    core_address   = 32'h0000_1000;
    core_read_req  = 1'b1;
    @(negedge clock);
    check("wb rd blocked stall", 32'(core_stall), 32'd1);
    check("wb rd blocked re", 32'(bus_read_enable), 32'd0);
    check("wb drain we", 32'(bus_write_enable), 32'd1);
    check("wb drain addr", bus_address, 32'h0000_1008);
    check("wb drain data", bus_write_data, 32'h1122_3344);
    next_cycle();
    bus_wait_req = 1'b0;
    @(negedge clock);
    check("wb accepted we", 32'(bus_write_enable), 32'd1);
    check("wb accepted re", 32'(bus_read_enable), 32'd0);
    next_cycle();
    @(negedge clock);
    check("wb rd issues", 32'(bus_read_enable), 32'd1);
    check("wb rd addr", bus_address, 32'h0000_1000);
    check("wb no we", 32'(bus_write_enable), 32'd0);
    next_cycle();
    bus_valid     = 1'b1;
    bus_read_data = 32'hA5A5_0001;
    @(negedge clock);
    check("wb rd rvalid", 32'(core_read_valid), 32'd1);
    check("wb rd rdata", core_read_data, 32'hA5A5_0001);
    next_cycle();
    idle_inputs();
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
